// File: rtl/jtag_data_if.sv
// Single-port synchronous RAM port driven by the JTAG data register.
// The master side issues accesses; the slave side (the RAM) returns read data
// one cycle after an enabled read.
interface jtag_data_if #(
  parameter int DW = 64,
  parameter int AW = 32
);
  logic          MEM_EN;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;

  modport master (
    output MEM_EN,
    output MEM_WE,
    output MEM_ADDR,
    output MEM_WDATA,
    input  MEM_RDATA
  );

  modport slave (
    input  MEM_EN,
    input  MEM_WE,
    input  MEM_ADDR,
    input  MEM_WDATA,
    output MEM_RDATA
  );
endinterface

// File: rtl/jtag_data.sv
// JTAG user data register in the TCK domain. Prefetches the word at the
// current pointer so Capture-DR returns it, writes the shifted-in word on
// Update-DR, post-increments the pointer, and zero-clears memory while INIT
// is low.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no access in flight; launches a pending write, else a fetch
// RD_ISSUE | read is on the RAM port this cycle
// RD_WAIT  | read data returns; kept only if nothing invalidated it
// WR_ISSUE | write is on the RAM port; pointer advances next edge
module jtag_data #(
  parameter int DW = 64,
  parameter int AW = 32
) (
  input  logic          TCK,
  input  logic          RESET,
  input  logic          SEL,
  input  logic          CAPTURE,
  input  logic          SHIFT,
  input  logic          UPDATE,
  input  logic          TDI,
  output logic          TDO,
  input  logic [AW-1:0] ADDR,
  input  logic          WR,
  input  logic          INC,
  input  logic          INIT,
  jtag_data_if.master   mem
);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE} state_t;

  state_t        state_q, state_d;
  logic [DW:0]   sr_q, sr_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] rbuf_q, rbuf_d;
  logic [DW-1:0] wbuf_q, wbuf_d;
  logic          valid_q, valid_d;
  logic          wpend_q, wpend_d;
  logic          fpend_q, fpend_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  assign TDO           = sr_q[0];
  assign mem.MEM_EN    = mem_en_q;
  assign mem.MEM_WE    = mem_we_q;
  assign mem.MEM_ADDR  = mem_addr_q;
  assign mem.MEM_WDATA = mem_wdata_q;

  // State register and all datapath flops; synchronous reset clears everything.
  always_ff @(posedge TCK) begin
    if (RESET) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      ptr_q       <= '0;
      addr_q      <= '0;
      rbuf_q      <= '0;
      wbuf_q      <= '0;
      valid_q     <= 1'b0;
      wpend_q     <= 1'b0;
      fpend_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      rbuf_q      <= rbuf_d;
      wbuf_q      <= wbuf_d;
      valid_q     <= valid_d;
      wpend_q     <= wpend_d;
      fpend_q     <= fpend_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next state: FSM first, then address tracking, then the DR strobes, so
  // later events override flags set by earlier ones in the same cycle.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    rbuf_d      = rbuf_q;
    wbuf_d      = wbuf_q;
    valid_d     = valid_q;
    wpend_d     = wpend_q;
    fpend_d     = fpend_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (!INIT) begin
      // Clear sweep: zero-write whatever address the sweep presents.
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = ADDR;
      mem_wdata_d = '0;
      ptr_d       = ADDR;
      addr_d      = ADDR;
      valid_d     = 1'b0;
      wpend_d     = 1'b0;
      fpend_d     = 1'b1;
      state_d     = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (wpend_q) begin
            state_d     = WR_ISSUE;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = wbuf_q;
          end else if (fpend_q) begin
            state_d    = RD_ISSUE;
            fpend_d    = 1'b0;
            mem_en_d   = 1'b1;
            mem_addr_d = ptr_q;
          end
        end
        WR_ISSUE: begin
          ptr_d   = ptr_q + AW'(INC);
          wpend_d = 1'b0;
          fpend_d = 1'b1;
          state_d = IDLE;
        end
        RD_ISSUE: state_d = RD_WAIT;
        RD_WAIT: begin
          // Anything pending since the read launched makes this data stale.
          if (!fpend_q && !wpend_q) begin
            rbuf_d  = mem.MEM_RDATA;
            valid_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (ADDR != addr_q) begin
        ptr_d   = ADDR;
        addr_d  = ADDR;
        valid_d = 1'b0;
        fpend_d = 1'b1;
      end

      if (SEL) begin
        if (CAPTURE) begin
          sr_d = {valid_q, rbuf_q};
        end else if (SHIFT) begin
          sr_d = {TDI, sr_q[DW:1]};
        end else if (UPDATE) begin
          if (WR) begin
            wbuf_d  = sr_q[DW-1:0];
            wpend_d = 1'b1;
            valid_d = 1'b0;
          end else if (INC) begin
            ptr_d   = ptr_d + AW'(1);
            valid_d = 1'b0;
            fpend_d = 1'b1;
          end
        end
      end
    end
  end

endmodule
